// File: rtl/dro_readout_deser.sv
// dro_readout_deser: decodes the DRO toggle-encoded out line into WIDTH-bit words.
// A toggle between strobes is a 1; a word is offered on a valid/ready port.
//   clk, rst_n     rising-edge clock, async active-low reset
//   din            DRO out level, sampled on strobe cycles
//   strobe, sync   bit capture; sync restarts the word at bit 0
//   clr            clears the sticky overflow / err flags
//   data_out/valid/ready  word output handshake, bit 0 = first bit
//   overflow, err  sticky: word dropped / din moved off-strobe
module dro_readout_deser #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             strobe,
  input  logic             sync,
  input  logic             clr,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  input  logic             ready,
  output logic             overflow,
  output logic             err
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             ref_lvl;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    pos;
  logic             bit_in;
  logic             done;
  logic             accept;
  logic             stray;
  logic             slot_free;

  always_comb begin
    bit_in    = din ^ ref_lvl;
    pos       = sync ? '0 : cnt;
    shreg_nxt = shreg;
    shreg_nxt[pos] = bit_in;
    done      = strobe && (pos == LAST);
    accept    = valid && ready;
    slot_free = !valid || ready;
    stray     = !strobe && (din != ref_lvl);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_lvl  <= 1'b0;
      shreg    <= '0;
      cnt      <= '0;
      data_out <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
      err      <= 1'b0;
    end else begin
      // Both strobe and stray-toggle cycles resync ref to din,
      // and on a quiet cycle din already equals ref.
      ref_lvl <= din;

      if (strobe) begin
        shreg <= shreg_nxt;
        cnt   <= done ? '0 : pos + 1'b1;
      end

      if (done && slot_free) begin
        data_out <= shreg_nxt;
        valid    <= 1'b1;
      end else if (accept) begin
        valid <= 1'b0;
      end

      if (done && !slot_free) begin
        overflow <= 1'b1;
      end else if (clr) begin
        overflow <= 1'b0;
      end

      if (stray) begin
        err <= 1'b1;
      end else if (clr) begin
        err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dro_readout_deser.sv
// tb_dro_readout_deser: scenario tasks plus a randomized run against
// a queue-based model of the toggle decoder.
module tb_dro_readout_deser;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         din = 1'b0;
  logic         strobe = 1'b0;
  logic         sync = 1'b0;
  logic         clr = 1'b0;
  logic         ready = 1'b0;
  logic [W-1:0] data_out;
  logic         valid;
  logic         overflow;
  logic         err;

  int vectors = 0;
  int miscompares = 0;

  logic         m_ref = 1'b0;
  bit           bits[$];
  logic [W-1:0] m_data = '0;
  logic         m_valid = 1'b0;
  logic         m_ovf = 1'b0;
  logic         m_err = 1'b0;

  dro_readout_deser #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .din(din),
    .strobe(strobe),
    .sync(sync),
    .clr(clr),
    .data_out(data_out),
    .valid(valid),
    .ready(ready),
    .overflow(overflow),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_ref = 1'b0;
    bits = {};
    m_data = '0;
    m_valid = 1'b0;
    m_ovf = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic model_edge();
    bit b;
    logic acc;
    logic [W-1:0] word;
    acc = m_valid && ready;
    if (clr) begin
      m_ovf = 1'b0;
      m_err = 1'b0;
    end
    if (strobe) begin
      b = din ^ m_ref;
      m_ref = din;
      if (sync) bits = {b};
      else bits.push_back(b);
      if (bits.size() == W) begin
        word = '0;
        foreach (bits[i]) word[i] = bits[i];
        bits = {};
        if (!m_valid || ready) begin
          m_data = word;
          m_valid = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
      end else if (acc) begin
        m_valid = 1'b0;
      end
    end else begin
      if (din != m_ref) begin
        m_err = 1'b1;
        m_ref = din;
      end
      if (acc) m_valid = 1'b0;
    end
  endtask

  task automatic step(input logic d, input logic s, input logic y,
                      input logic c, input logic r);
    din = d;
    strobe = s;
    sync = y;
    clr = c;
    ready = r;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    model_reset();
    #3;
    vectors++;
    if (data_out !== '0) begin
      miscompares++;
      $display("FAIL reset_data got %h want 00", data_out);
    end
    vectors++;
    if (valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_valid got %b want 0", valid);
    end
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_overflow got %b want 0", overflow);
    end
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_err got %b want 0", err);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic lv [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      step(lv[i], 1'b1, i == 0, 1'b0, 1'b0);
      if (i == 6) begin
        vectors++;
        if (valid !== 1'b0) begin
          miscompares++;
          $display("FAIL basic_early_valid got %b want 0", valid);
        end
      end
    end
    vectors++;
    if ({data_out, valid, err} !== {8'h85, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL basic got d=%h v=%b e=%b want d=85 v=1 e=0",
               data_out, valid, err);
    end
    step(din, 1'b0, 1'b0, 1'b0, 1'b1);
    vectors++;
    if ({data_out, valid, overflow, err} !==
        {m_data, m_valid, m_ovf, m_err}) begin
      miscompares++;
      $display("FAIL basic_drain got v=%b want v=%b", valid, m_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w1;
    logic [W-1:0] w2;
    for (int i = 0; i < 16; i++) begin
      step(~din, 1'b1, i == 0, 1'b0, 1'b1);
      vectors++;
      if ({data_out, valid, overflow, err} !==
          {m_data, m_valid, m_ovf, m_err}) begin
        miscompares++;
        $display("FAIL b2b_ff step %0d got d=%h v=%b want d=%h v=%b",
                 i, data_out, valid, m_data, m_valid);
      end
      if (i == 7 || i == 15) begin
        vectors++;
        if ({data_out, valid} !== {8'hFF, 1'b1}) begin
          miscompares++;
          $display("FAIL b2b_word%0d got d=%h v=%b want d=ff v=1",
                   i / 8, data_out, valid);
        end
      end
    end
    step(din, 1'b0, 1'b0, 1'b0, 1'b1);
    w1 = W'($urandom);
    w2 = ~w1;
    for (int i = 0; i < 16; i++) begin
      logic b;
      b = (i < 8) ? w1[i] : w2[i-8];
      step(b ? ~din : din, 1'b1, i == 0, 1'b0, i == 15);
      if (i >= 7) begin
        vectors++;
        if (valid !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b_gap step %0d got v=%b want v=1", i, valid);
        end
      end
    end
    vectors++;
    if ({data_out, overflow} !== {w2, 1'b0}) begin
      miscompares++;
      $display("FAIL b2b_accept_load got d=%h o=%b want d=%h o=0",
               data_out, overflow, w2);
    end
    step(din, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    logic [W-1:0] w1;
    logic [W-1:0] w2;
    w1 = W'($urandom);
    w2 = W'($urandom);
    for (int i = 0; i < 16; i++) begin
      logic b;
      b = (i < 8) ? w1[i] : w2[i-8];
      step(b ? ~din : din, 1'b1, i == 0, 1'b0, 1'b0);
    end
    vectors++;
    if ({data_out, valid, overflow} !== {w1, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL bp_hold got d=%h v=%b o=%b want d=%h v=1 o=1",
               data_out, valid, overflow, w1);
    end
    step(din, 1'b0, 1'b0, 1'b1, 1'b1);
    vectors++;
    if ({data_out, valid, overflow} !== {w1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL bp_clr got d=%h v=%b o=%b want d=%h v=0 o=0",
               data_out, valid, overflow, w1);
    end
  endtask

  task automatic test_stray();
    step(~din, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL stray_err got %b want 1", err);
    end
    for (int i = 0; i < 8; i++) step(din, 1'b1, i == 0, 1'b0, 1'b0);
    vectors++;
    if ({data_out, valid, err} !== {8'h00, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL stray_bit got d=%h v=%b e=%b want d=00 v=1 e=1",
               data_out, valid, err);
    end
    step(din, 1'b0, 1'b0, 1'b1, 1'b1);
    vectors++;
    if ({valid, err} !== 2'b00) begin
      miscompares++;
      $display("FAIL stray_clr got v=%b e=%b want v=0 e=0", valid, err);
    end
  endtask

  task automatic test_resync();
    for (int i = 0; i < 3; i++) begin
      step($urandom_range(0, 1) ? ~din : din, 1'b1, i == 0, 1'b0, 1'b0);
    end
    step(~din, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step(din, 1'b1, 1'b0, 1'b0, 1'b0);
      if (i < 6) begin
        vectors++;
        if (valid !== 1'b0) begin
          miscompares++;
          $display("FAIL resync_early step %0d got v=%b want 0", i, valid);
        end
      end
    end
    vectors++;
    if ({data_out, valid, overflow, err} !== {8'h01, 1'b1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL resync got d=%h v=%b o=%b e=%b want d=01 v=1 o=0 e=0",
               data_out, valid, overflow, err);
    end
    step(din, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, i == 0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if ({data_out, valid, overflow, err} !== '0) begin
      miscompares++;
      $display("FAIL midreset got d=%h v=%b o=%b e=%b want all 0",
               data_out, valid, overflow, err);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    vectors++;
    if ({data_out, valid, err} !== {8'h01, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL midreset_word got d=%h v=%b e=%b want d=01 v=1 e=0",
               data_out, valid, err);
    end
  endtask

  task automatic test_random();
    logic s;
    logic d;
    for (int i = 0; i < 400; i++) begin
      s = $urandom_range(0, 3) != 0;
      if (s) d = $urandom_range(0, 1) ? ~din : din;
      else d = ($urandom_range(0, 15) == 0) ? ~din : din;
      step(d, s, s && ($urandom_range(0, 19) == 0),
           $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
      vectors++;
      if ({data_out, valid, overflow, err} !==
          {m_data, m_valid, m_ovf, m_err}) begin
        miscompares++;
        $display("FAIL random %0d got d=%h v=%b o=%b e=%b want d=%h v=%b o=%b e=%b",
                 i, data_out, valid, overflow, err,
                 m_data, m_valid, m_ovf, m_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_stray();
    test_resync();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
